// File: rtl/framebuffer_pixel_writer.sv
// ============================================================================
// framebuffer_pixel_writer: buffers x/y/colour pixels and writes them to the framebuffer RAM.
// Rev 1.0
// ============================================================================
`default_nettype none

module framebuffer_pixel_writer #(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [6:0]  in_y,
  input  logic [8:0]  in_colour,
  input  logic        in_last,
  output logic [14:0] mem_address,
  output logic [8:0]  mem_data,
  output logic        mem_wren,
  output logic [14:0] pixel_count,
  output logic        frame_done,
  output logic        oob_err
);

  localparam int              PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CNT_W   = PTR_W + 1;
  localparam int              ENTRY_W = 8 + 7 + 9 + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [14:0]     PIX_MAX = 15'(SCREEN_W * SCREEN_H);
  localparam logic [7:0]      X_LIM   = 8'(SCREEN_W);
  localparam logic [7:0]      Y_LIM   = 8'(SCREEN_H);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  logic [ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               in_ready_q;
  logic [0:0]         state_q, state_d;
  logic               push, pop;

  logic               s1_valid_q;
  logic [ENTRY_W-1:0] s1_entry_q;

  logic [7:0]  s1_x;
  logic [6:0]  s1_y;
  logic [8:0]  s1_colour;
  logic        s1_last;
  logic        s1_in_range;
  logic        s1_write;
  logic [14:0] s1_address;

  logic        mem_wren_q, mem_wren_d;
  logic [14:0] mem_address_q, mem_address_d;
  logic [8:0]  mem_data_q, mem_data_d;
  logic [14:0] pixel_count_q, pixel_count_d, count_base;
  logic        frame_done_q, frame_done_d;
  logic        oob_err_q, oob_err_d;

  // ---------------------------------------------------------------- FIFO
  assign push    = in_valid && in_ready_q;
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {in_x, in_y, in_colour, in_last};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      in_ready_q <= (count_d != DEPTH_C);
    end
  end

  // ---------------------------------------------------------- write FSM
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    if (count_d != '0) state_d = ST_WRITE;
  end

  always_comb begin
    pop = 1'b0;
    if (state_q == ST_WRITE) pop = 1'b1;
  end

  // Popped entry is held one cycle so address math sits in its own stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_entry_q <= '0;
    end else begin
      s1_valid_q <= pop;
      if (pop) s1_entry_q <= fifo_mem_q[rd_ptr_q];
    end
  end

  // ------------------------------------------------------- output stage
  assign {s1_x, s1_y, s1_colour, s1_last} = s1_entry_q;
  assign s1_in_range = (s1_x < X_LIM) && ({1'b0, s1_y} < Y_LIM);
  assign s1_write    = s1_valid_q && s1_in_range;
  assign s1_address  = 15'(s1_y) * 15'(SCREEN_W) + 15'(s1_x);

  always_comb begin
    mem_wren_d    = s1_write;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    if (s1_write) begin
      mem_address_d = s1_address;
      mem_data_d    = s1_colour;
    end
    frame_done_d  = s1_valid_q && s1_last;
    oob_err_d     = oob_err_q || (s1_valid_q && !s1_in_range);
    // The pass restarts on the edge after frame_done, even if a write lands then.
    count_base    = frame_done_q ? 15'd0 : pixel_count_q;
    pixel_count_d = count_base;
    if (s1_write && (count_base != PIX_MAX)) pixel_count_d = count_base + 15'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_wren_q    <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      pixel_count_q <= '0;
      frame_done_q  <= 1'b0;
      oob_err_q     <= 1'b0;
    end else begin
      mem_wren_q    <= mem_wren_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      pixel_count_q <= pixel_count_d;
      frame_done_q  <= frame_done_d;
      oob_err_q     <= oob_err_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign mem_wren    = mem_wren_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign pixel_count = pixel_count_q;
  assign frame_done  = frame_done_q;
  assign oob_err     = oob_err_q;

endmodule

`default_nettype wire

// File: tb/tb_framebuffer_pixel_writer.sv
// ============================================================================
// tb_framebuffer_pixel_writer: scoreboard bench for framebuffer_pixel_writer.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_framebuffer_pixel_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_x = '0;
  logic [6:0]  in_y = '0;
  logic [8:0]  in_colour = '0;
  logic        in_last = 1'b0;
  logic [14:0] mem_address;
  logic [8:0]  mem_data;
  logic        mem_wren;
  logic [14:0] pixel_count;
  logic        frame_done;
  logic        oob_err;

  always #5 clk = ~clk;

  framebuffer_pixel_writer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_colour   (in_colour),
    .in_last     (in_last),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .pixel_count (pixel_count),
    .frame_done  (frame_done),
    .oob_err     (oob_err)
  );

  typedef struct packed {
    logic        wr;
    logic [14:0] addr;
    logic [8:0]  data;
    logic        fd;
    logic [14:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   model_cnt = 0;
  bit   model_oob = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: a pass is a run of accepted pixels ending in last; in-range
  // pixels produce a write at y*160+x, out-of-range ones are silently dropped.
  task automatic model_accept(input logic [7:0] x, input logic [6:0] y,
                              input logic [8:0] c, input logic l);
    exp_t e;
    int   a;
    if (int'(x) < 160 && int'(y) < 120) begin
      if (model_cnt < 19200) model_cnt++;
      a      = int'(y) * 160 + int'(x);
      e.wr   = 1'b1;
      e.addr = 15'(a);
      e.data = c;
      e.fd   = l;
      e.cnt  = 15'(model_cnt);
      exp_q.push_back(e);
      if (l) model_cnt = 0;
    end else begin
      model_oob = 1'b1;
      if (l) begin
        e.wr   = 1'b0;
        e.addr = '0;
        e.data = '0;
        e.fd   = 1'b1;
        e.cnt  = 15'(model_cnt);
        exp_q.push_back(e);
        model_cnt = 0;
      end
    end
  endtask

  // Monitor: every strobe or frame_done must match the oldest expected event.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mem_wren === 1'b1 || frame_done === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output wren=%0b addr=%0d fd=%0b required=no_output",
                 mem_wren, mem_address, frame_done);
      end else begin
        e = exp_q.pop_front();
        if (mem_wren !== e.wr || frame_done !== e.fd || pixel_count !== e.cnt ||
            (e.wr && (mem_address !== e.addr || mem_data !== e.data))) begin
          bad++;
          $display("FAIL output_event actual wren=%0b addr=%0d data=%0h fd=%0b cnt=%0d required wren=%0b addr=%0d data=%0h fd=%0b cnt=%0d",
                   mem_wren, mem_address, mem_data, frame_done, pixel_count,
                   e.wr, e.addr, e.data, e.fd, e.cnt);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [7:0] x, input logic [6:0] y,
                      input logic [8:0] c, input logic l);
    bit acc;
    int guard;
    acc       = 1'b0;
    guard     = 0;
    in_valid  = 1'b1;
    in_x      = x;
    in_y      = y;
    in_colour = c;
    in_last   = l;
    while (!acc) begin
      acc = (in_ready === 1'b1);
      if (acc) model_accept(x, y, c, l);
      @(negedge clk);
      guard++;
      if (!acc && guard > 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout actual=in_ready_low required=accept");
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    model_oob = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] rx;
    logic [6:0] ry;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_wren", mem_wren, 0);
    check("rst_addr", mem_address, 0);
    check("rst_data", mem_data, 0);
    check("rst_count", pixel_count, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_oob", oob_err, 0);

    // Single pixel with exact latency
    send(8'd3, 7'd2, 9'h1FF, 1'b1);
    in_valid = 1'b0;
    check("lat_after_n", mem_wren, 0);
    @(negedge clk);
    check("lat_after_n1", mem_wren, 0);
    @(negedge clk);
    check("lat_wren", mem_wren, 1);
    check("lat_addr", mem_address, 323);
    check("lat_data", mem_data, 9'h1FF);
    check("lat_frame_done", frame_done, 1);
    check("lat_count", pixel_count, 1);
    @(negedge clk);
    check("post_count_zero", pixel_count, 0);
    check("post_wren_low", mem_wren, 0);
    check("post_addr_hold", mem_address, 323);
    idle(3);

    // Six back-to-back pixels
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)),
           9'($urandom), (i == 5));
    end
    idle(5);

    // Out-of-range drop
    send(8'd160, 7'd0, 9'h011, 1'b0);
    send(8'd0, 7'd120, 9'h022, 1'b0);
    send(8'd5, 7'd5, 9'h0AA, 1'b1);
    idle(6);
    check("oob_set", oob_err, 1);
    check("oob_count_after", pixel_count, 0);

    // Continuous stream: simultaneous push/pop must never stall the producer
    for (int i = 0; i < 10; i++) begin
      check("stream_in_ready", in_ready, 1);
      send(8'(i * 17), 7'(i * 11), 9'(i * 37), (i == 9));
    end
    idle(5);

    // Randomised pixels, gaps and pass boundaries
    for (int i = 0; i < 400; i++) begin
      rx = 8'($urandom_range(0, 170));
      ry = 7'($urandom_range(0, 127));
      send(rx, ry, 9'($urandom), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(6);
    check("rand_oob", oob_err, 32'(model_oob));
    check("rand_count_idle", pixel_count, 32'(model_cnt));

    // Full frame in raster order
    do_reset();
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) begin
        send(8'(x), 7'(y), 9'(x + y), (x == 159 && y == 119));
      end
    end
    idle(6);
    check("frame_count_cleared", pixel_count, 0);
    check("frame_oob_clear", oob_err, 0);

    // Reset mid-pass discards the queue
    send(8'd200, 7'd3, 9'h003, 1'b0);
    send(8'd1, 7'd1, 9'h101, 1'b0);
    send(8'd2, 7'd2, 9'h102, 1'b1);
    in_valid = 1'b0;
    check("midpass_oob_before", oob_err, 1);
    do_reset();
    check("midpass_wren", mem_wren, 0);
    check("midpass_in_ready", in_ready, 1);
    check("midpass_count", pixel_count, 0);
    check("midpass_oob", oob_err, 0);
    idle(8);
    check("midpass_wren_later", mem_wren, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/framebuffer_pixel_writer.md
Name: framebuffer_pixel_writer

Overview:
- Receive end of the pixel-plot stream that drawing blocks (map, sprite and text drawers) emit as x/y/colour.
- Accepts pixels through a valid/ready handshake and buffers them in a small FIFO.
- Translates each 160x120 coordinate to a linear address, y*160+x, and writes the colour into the 19200x9 framebuffer RAM port.
- Counts written pixels and reports frame completion back to the drawing FSM.

Parameters:
- SCREEN_W, 160, pixel columns; valid x is 0..SCREEN_W-1.
- SCREEN_H, 120, pixel rows; valid y is 0..SCREEN_H-1.
- FIFO_DEPTH, 4, input buffer entries; must be a power of two and at least 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  producer presents a pixel.
- in_ready  out  1  block can accept a pixel; equals !fifo_full, registered.
- in_x  in  8  pixel column.
- in_y  in  7  pixel row.
- in_colour  in  9  3:3:3 RGB colour.
- in_last  in  1  marks the final pixel of a drawing pass.
- mem_address  out  15  framebuffer write address.
- mem_data  out  9  framebuffer write data.
- mem_wren  out  1  one-cycle framebuffer write strobe.
- pixel_count  out  15  pixels written in the current pass.
- frame_done  out  1  one-cycle pulse when the pass completes.
- oob_err  out  1  sticky flag: an out-of-range pixel was dropped.

Behaviour:
- Reset (sync, active-high), effective on the next posedge:
  - FIFO emptied; in_ready=1.
  - mem_wren=0, mem_address=0, mem_data=0.
  - pixel_count=0, frame_done=0, oob_err=0.
  - Reset mid-pass discards all buffered pixels; no write strobe is issued in the cycle after reset.
- Handshake:
  - A pixel is accepted when in_valid && in_ready at a posedge.
  - Inputs are ignored when in_ready=0, and the producer must hold them.
  - in_ready is derived from the registered occupancy, so it deasserts in the cycle after the FIFO becomes full.
- FIFO:
  - Each entry is {x, y, colour, last}, FIFO_DEPTH deep.
  - Push and pop in the same cycle leave occupancy unchanged.
  - There is no push when full and no pop when empty.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Write stage, two states:
  - IDLE: entered when the FIFO is empty; mem_wren=0.
  - WRITE: when the FIFO is non-empty, pop one entry per cycle and register the outputs.
  - Latency: a pixel accepted at edge N into an empty FIFO pops at edge N+1. mem_wren=1 with its address and data is visible during the cycle after edge N+2.
  - Sustained throughput is 1 pixel per cycle.
- Address:
  - mem_address = y*SCREEN_W + x, computed as (y<<7)+(y<<5)+x in 15 bits with no overflow for valid coordinates.
  - Valid range is 0..19199, for example (159,119) -> 19199.
- Out-of-range pixels (x >= SCREEN_W or y >= SCREEN_H):
  - The entry is popped with no write strobe and is not counted.
  - oob_err is set and stays set until reset.
- pixel_count:
  - Increments by 1 on every issued write.
  - Saturates at 19200.
- frame_done:
  - Pulses for exactly one cycle, coincident with the write strobe of the entry carrying last=1.
  - If that entry is out of range, the pulse comes in the cycle its write would have occurred.
  - pixel_count returns to 0 on the edge after frame_done; the count shown during the pulse includes the last pixel.
- mem_data and mem_address hold their last values when mem_wren=0.

Test Plan:
- Reset then single pixel: x=3, y=2, colour=9'h1FF, last=1 at edge N.
  - Expect mem_wren=1, mem_address=323, mem_data=1FF after edge N+2.
  - Expect frame_done pulse with pixel_count=1, then pixel_count=0.
- Full-frame stream: 19200 pixels raster order, in_valid held, last on (159,119).
  - Expect 19200 strobes with addresses 0..19199 in order and one frame_done pulse.
  - Expect pixel_count=19200 during the pulse.
- Backpressure: send 6 pixels in 6 consecutive cycles with the write stage active.
  - Verify in_ready never causes a dropped or duplicated pixel.
  - Verify the output order equals the input order.
- Out-of-range drop: pixels (160,0), (0,120), (5,5) with last on the final one.
  - Expect one write at address 805 and oob_err=1.
  - Expect pixel_count=1 at frame_done.
- Reset mid-pass: 3 pixels queued, then reset asserted for 1 cycle.
  - Expect no mem_wren afterwards, in_ready=1, pixel_count=0, oob_err=0.
- Simultaneous push and pop at occupancy 2 for 10 cycles: occupancy stays 2, in_ready stays 1, and addresses are correct through pointer wrap.
